// File: rtl/boot_pkg.sv
// Shared boot-sequencing types and instruction-field constants.
// The CPU decoder imports the opcode slice and halt/NOP encodings from here too.
package boot_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALT   = 2'd3
  } boot_state_e;

  localparam int          OPC_MSB     = 31;
  localparam int          OPC_LSB     = 26;
  localparam logic [5:0]  HALT_OPCODE = 6'd24;
  localparam logic [31:0] NOP_WORD    = 32'hFC00_0000;
  localparam int          CNT_W       = 4;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/boot_stall_counter.sv
// 4-bit down counter timing the BOOT->RUN drain window.
// Clear beats load, load beats decrement; zero_o reflects the registered count.
module boot_stall_counter
  import boot_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/boot_fetch_controller.sv
// Selects the CPU fetch source (BIOS ROM, then instruction memory) with a stall window at hand-off.
// Optional macro BOOT_FETCH_COUNT_EN adds a saturating fetch_count of RUN-phase fetches.
module boot_fetch_controller
  import boot_pkg::*;
#(
  parameter int HANDOFF_ADDR  = 16,
  parameter int BIOS_DEPTH    = 201,
  parameter int SWITCH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic [31:0] bios_instr,
  input  logic [31:0] mem_instr,
  input  logic        reboot_req,
  output logic [31:0] bios_addr,
  output logic [31:0] mem_addr,
  output logic [31:0] instruction,
  output logic        cpu_stall,
  output logic        boot_done,
  output logic        halted,
`ifdef BOOT_FETCH_COUNT_EN
  output logic [31:0] fetch_count,
`endif
  output logic        bios_fault
);

  localparam logic [31:0]      HANDOFF_PC  = 32'(HANDOFF_ADDR);
  localparam logic [31:0]      BIOS_END    = 32'(BIOS_DEPTH);
  localparam logic [CNT_W-1:0] SWITCH_LOAD = CNT_W'(SWITCH_CYCLES - 1);

  if ((SWITCH_CYCLES < 1) || (SWITCH_CYCLES > 15)) begin : g_bad_switch_cycles
    $error("SWITCH_CYCLES must be in 1..15");
  end

  boot_state_e state_q;
  logic        bios_fault_q;
  logic        pc_past_bios;
  logic        pc_at_handoff;
  logic        is_halt_word;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  assign pc_past_bios  = (pc >= BIOS_END);
  assign pc_at_handoff = (pc == HANDOFF_PC);
  assign is_halt_word  = (opcode_of(mem_instr) == HALT_OPCODE);

  assign cnt_load = (state_q == ST_BOOT) && pc_at_handoff && !reboot_req;
  assign cnt_dec  = (state_q == ST_SWITCH) && !cnt_zero && !reboot_req;

  boot_stall_counter u_stall_counter (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .clear_i    (reboot_req),
    .load_i     (cnt_load),
    .load_val_i (SWITCH_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Reboot outranks every transition, including hand-off and halt detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      bios_fault_q <= 1'b0;
    end else if (reboot_req) begin
      state_q      <= ST_BOOT;
      bios_fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (pc_past_bios) begin
            bios_fault_q <= 1'b1;
          end
          if (pc_at_handoff) begin
            state_q <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          if (cnt_zero) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (is_halt_word) begin
            state_q <= ST_HALT;
          end
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

`ifdef BOOT_FETCH_COUNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_q <= '0;
    end else if (reboot_req) begin
      fetch_count_q <= '0;
    end else if ((state_q == ST_RUN) && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

  // Control outputs depend only on registered state, never on pc.
  always_comb begin
    bios_addr   = '0;
    mem_addr    = '0;
    instruction = NOP_WORD;
    cpu_stall   = 1'b0;
    boot_done   = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        bios_addr   = pc;
        instruction = pc_past_bios ? NOP_WORD : bios_instr;
      end
      ST_SWITCH: begin
        cpu_stall = 1'b1;
        boot_done = 1'b1;
      end
      ST_RUN: begin
        mem_addr    = pc;
        instruction = mem_instr;
        boot_done   = 1'b1;
      end
      default: begin
        cpu_stall = 1'b1;
        boot_done = 1'b1;
        halted    = 1'b1;
      end
    endcase
  end

  assign bios_fault = bios_fault_q;

endmodule

// File: tb/tb_boot_fetch_controller.sv
// Scoreboard bench for boot_fetch_controller: expected per-cycle outputs are queued
// as stimulus is driven and compared on the following falling edge.
module tb_boot_fetch_controller;

  localparam logic [31:0] NOP  = 32'hFC00_0000;
  localparam logic [31:0] HALT = 32'h6000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] bios_instr = '0;
  logic [31:0] mem_instr = '0;
  logic        reboot_req = 1'b0;
  logic [31:0] bios_addr, mem_addr, instruction;
  logic        cpu_stall, boot_done, halted, bios_fault;
`ifdef BOOT_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  boot_fetch_controller dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc          (pc),
    .bios_instr  (bios_instr),
    .mem_instr   (mem_instr),
    .reboot_req  (reboot_req),
    .bios_addr   (bios_addr),
    .mem_addr    (mem_addr),
    .instruction (instruction),
    .cpu_stall   (cpu_stall),
    .boot_done   (boot_done),
    .halted      (halted),
`ifdef BOOT_FETCH_COUNT_EN
    .fetch_count (fetch_count),
`endif
    .bios_fault  (bios_fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] baddr;
    logic [31:0] maddr;
    logic        stall;
    logic        done;
    logic        halt;
    logic        fault;
  } obs_t;

  typedef struct packed {
    obs_t v;
    obs_t m;
  } sb_t;

  sb_t   sb_q[$];
  string nm_q[$];
  int    errors = 0;
  int    checks = 0;

  localparam obs_t ALL_CARE = '1;
  localparam obs_t NO_ADDR  = '{instr: '1, baddr: '0, maddr: '0, stall: 1'b1,
                                done: 1'b1, halt: 1'b1, fault: 1'b1};

  function automatic logic [31:0] rom_word(input logic [31:0] p);
    return 32'hB000_0000 | p;
  endfunction

  function automatic logic [31:0] rand_mem();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'd24) w[26] = 1'b1;
    return w;
  endfunction

  function automatic sb_t e_boot(input logic [31:0] p, input logic f);
    sb_t s;
    s.v = '{instr: (p >= 32'd201) ? NOP : rom_word(p), baddr: p, maddr: '0,
            stall: 1'b0, done: 1'b0, halt: 1'b0, fault: f};
    s.m = ALL_CARE;
    return s;
  endfunction

  function automatic sb_t e_switch(input logic f);
    sb_t s;
    s.v = '{instr: NOP, baddr: '0, maddr: '0, stall: 1'b1, done: 1'b1, halt: 1'b0, fault: f};
    s.m = NO_ADDR;
    return s;
  endfunction

  function automatic sb_t e_run(input logic [31:0] p, input logic [31:0] mi, input logic f);
    sb_t s;
    s.v = '{instr: mi, baddr: '0, maddr: p, stall: 1'b0, done: 1'b1, halt: 1'b0, fault: f};
    s.m = ALL_CARE;
    return s;
  endfunction

  function automatic sb_t e_halt(input logic f);
    sb_t s;
    s.v = '{instr: NOP, baddr: '0, maddr: '0, stall: 1'b1, done: 1'b1, halt: 1'b1, fault: f};
    s.m = NO_ADDR;
    return s;
  endfunction

  function automatic obs_t sample();
    return {instruction, bios_addr, mem_addr, cpu_stall, boot_done, halted, bios_fault};
  endfunction

  task automatic drive(input logic [31:0] p, input logic [31:0] mi, input logic rb);
    pc         = p;
    bios_instr = rom_word(p);
    mem_instr  = mi;
    reboot_req = rb;
  endtask

  task automatic test_reset();
    obs_t got;
    sb_t  e;
    drive(32'd0, rand_mem(), 1'b0);
    reset_n = 1'b0;
    sb_q.push_back(e_boot(32'd0, 1'b0));
    nm_q.push_back("reset_state");
    @(negedge clock);
    got = sample();
    e = sb_q.pop_front();
    checks++;
    if ((got & e.m) !== (e.v & e.m)) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm_q.pop_front(), got, e.v);
    end else void'(nm_q.pop_front());
`ifdef BOOT_FETCH_COUNT_EN
    checks++;
    if (fetch_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_fetch_count: got %0d want 0", fetch_count);
    end
`endif
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_boot_fetch();
    obs_t got;
    sb_t  e;
    for (int i = 0; i < 16; i++) begin
      drive(32'(i), rand_mem(), 1'b0);
      sb_q.push_back(e_boot(32'(i), 1'b0));
      nm_q.push_back($sformatf("boot_pc%0d", i));
      @(negedge clock);
      got = sample();
      e = sb_q.pop_front();
      checks++;
      if ((got & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s: got %h want %h", nm_q.pop_front(), got, e.v);
      end else void'(nm_q.pop_front());
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_handoff_run_halt();
    obs_t        got;
    sb_t         e;
    logic [31:0] mi;
    // 1 hand-off cycle, 2 stall cycles, 9 ordinary RUN fetches, the halt word,
    // 4 HALT cycles, the reboot cycle, then the first BOOT cycle afterwards.
    for (int c = 0; c < 19; c++) begin
      mi = rand_mem();
      if (c == 0) begin
        drive(32'd16, mi, 1'b0);
        sb_q.push_back(e_boot(32'd16, 1'b0));
        nm_q.push_back("handoff_cycle");
      end else if (c < 3) begin
        drive(32'd16, mi, 1'b0);
        sb_q.push_back(e_switch(1'b0));
        nm_q.push_back($sformatf("switch_stall%0d", c));
      end else if (c < 12) begin
        drive(32'(13 + c), mi, 1'b0);
        sb_q.push_back(e_run(32'(13 + c), mi, 1'b0));
        nm_q.push_back($sformatf("run_fetch%0d", c - 3));
      end else if (c == 12) begin
        drive(32'd25, HALT, 1'b0);
        sb_q.push_back(e_run(32'd25, HALT, 1'b0));
        nm_q.push_back("halt_word_delivered");
      end else if (c < 17) begin
        drive(32'd26, (c == 14) ? HALT : mi, 1'b0);
        sb_q.push_back(e_halt(1'b0));
        nm_q.push_back($sformatf("halt_hold%0d", c - 13));
      end else if (c == 17) begin
        drive(32'd26, mi, 1'b1);
        sb_q.push_back(e_halt(1'b0));
        nm_q.push_back("halt_reboot_cycle");
      end else begin
        drive(32'd0, mi, 1'b0);
        sb_q.push_back(e_boot(32'd0, 1'b0));
        nm_q.push_back("after_reboot_boot");
      end
      @(negedge clock);
      got = sample();
      e = sb_q.pop_front();
      checks++;
      if ((got & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s: got %h want %h", nm_q.pop_front(), got, e.v);
      end else void'(nm_q.pop_front());
`ifdef BOOT_FETCH_COUNT_EN
      if (c == 13 || c == 16 || c == 18) begin
        checks++;
        if (fetch_count !== ((c == 18) ? 32'd0 : 32'd10)) begin
          errors++;
          $display("FAIL fetch_count_c%0d: got %0d want %0d", c, fetch_count,
                   (c == 18) ? 0 : 10);
        end
      end
`endif
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_bios_fault();
    logic [31:0] pcs[7] = '{32'd200, 32'd201, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'd7, 32'd7};
    logic        rbs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        flt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    obs_t got;
    sb_t  e;
    for (int i = 0; i < 7; i++) begin
      drive(pcs[i], rand_mem(), rbs[i]);
      sb_q.push_back(e_boot(pcs[i], flt[i]));
      nm_q.push_back($sformatf("fault_step%0d", i));
      @(negedge clock);
      got = sample();
      e = sb_q.pop_front();
      checks++;
      if ((got & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s: got %h want %h", nm_q.pop_front(), got, e.v);
      end else void'(nm_q.pop_front());
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reboot_beats_handoff();
    logic [31:0] pcs[3] = '{32'd16, 32'd0, 32'd1};
    logic        rbs[3] = '{1'b1, 1'b0, 1'b0};
    obs_t got;
    sb_t  e;
    for (int i = 0; i < 3; i++) begin
      drive(pcs[i], rand_mem(), rbs[i]);
      sb_q.push_back(e_boot(pcs[i], 1'b0));
      nm_q.push_back($sformatf("reboot_vs_handoff%0d", i));
      @(negedge clock);
      got = sample();
      e = sb_q.pop_front();
      checks++;
      if ((got & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s: got %h want %h", nm_q.pop_front(), got, e.v);
      end else void'(nm_q.pop_front());
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset_mid_switch();
    obs_t got;
    sb_t  e;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        drive(32'd16, rand_mem(), 1'b0);
        sb_q.push_back(e_boot(32'd16, 1'b0));
        nm_q.push_back("mid_switch_handoff");
      end else if (i == 1) begin
        drive(32'd16, rand_mem(), 1'b0);
        sb_q.push_back(e_switch(1'b0));
        nm_q.push_back("mid_switch_stall");
      end else begin
        drive(32'(i + 1), rand_mem(), 1'b0);
        sb_q.push_back(e_boot(32'(i + 1), 1'b0));
        nm_q.push_back($sformatf("post_reset_boot%0d", i));
      end
      @(negedge clock);
      got = sample();
      e = sb_q.pop_front();
      checks++;
      if ((got & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s: got %h want %h", nm_q.pop_front(), got, e.v);
      end else void'(nm_q.pop_front());
      if (i == 1) begin
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_stall, boot_done, halted} !== 3'b000) begin
          errors++;
          $display("FAIL async_reset_clears_stall: got stall/done/halt=%b want 000",
                   {cpu_stall, boot_done, halted});
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
      end else begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boot_fetch();
    test_handoff_run_halt();
    test_bios_fault();
    test_reboot_beats_handoff();
    test_reset_mid_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
